sd_cmd_response_receiver: RTL and testbench

Receives SD card responses on the CMD line, the opposite direction to the host command path clocked by `sd_clock_divider`. Runs in the `CLK` domain and samples `CMD_IN` on each rising edge of the divided `SD_CLK`, which is generated from the same `CLK`. Supports 48-bit short responses and 136-bit R2 responses, with CRC7, end-bit and timeout checking. Sits between the SD pad logic and the command controller FSM.

---
 rtl/sd_cmd_rx_pkg.sv | 23 ++
 rtl/sd_crc7_serial.sv | 34 +++
 rtl/sd_cmd_response_receiver.sv | 176 +++++++++++++++++
 tb/tb_sd_cmd_response_receiver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_rx_pkg.sv
// Shared types and constants for the SD CMD-line response receiver and its CRC7 helper.
package sd_cmd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECV,
    ST_DONE
  } rx_state_e;

  localparam int SD_RSP_SHORT_LEN = 48;
  localparam int SD_RSP_LONG_LEN  = 136;

  localparam logic [6:0] SD_CRC7_POLY = 7'h09;

  // One serial CRC7 step, MSB-first, feedback taken from the register MSB.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1); CLR wins over EN, shared by the CMD transmit and receive paths.
module sd_crc7_serial
  import sd_cmd_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       EN,
  input  logic       BIT_IN,
  output logic [6:0] CRC
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (CLR) begin
      crc_d = 7'h00;
    end else if (EN) begin
      crc_d = crc7_step(crc_q, BIT_IN);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;

endmodule

// File: rtl/sd_cmd_response_receiver.sv
// Receives 48-bit and 136-bit SD responses on CMD, sampling on divided SD_CLK rises,
// with CRC7, end-bit and start-bit timeout checking.
module sd_cmd_response_receiver
  import sd_cmd_rx_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SD_CLK,
  input  logic                 CMD_IN,
  input  logic                 START,
  input  logic                 LONG,
  input  logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT,
  output logic                 BUSY,
  output logic                 RSP_VALID,
  output logic [127:0]         RSP_DATA,
  output logic                 CRC_ERR,
  output logic                 END_ERR,
  output logic                 TIMEOUT
);

  localparam logic [7:0] SHORT_LAST_CNT     = 8'(SD_RSP_SHORT_LEN - 1);
  localparam logic [7:0] LONG_LAST_CNT      = 8'(SD_RSP_LONG_LEN - 1);
  localparam logic [7:0] SHORT_CRC_LAST_CNT = 8'(SD_RSP_SHORT_LEN - 9);
  localparam logic [7:0] LONG_CRC_FIRST_CNT = 8'(SD_RSP_LONG_LEN - 128);
  localparam logic [7:0] LONG_CRC_LAST_CNT  = 8'(SD_RSP_LONG_LEN - 9);

  rx_state_e            state_q, state_d;
  logic                 sd_clk_q;
  logic                 long_q, long_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]           bcnt_q, bcnt_d;
  logic [135:0]         frame_q, frame_d;
  logic [127:0]         data_q, data_d;
  logic                 crc_err_q, crc_err_d;
  logic                 end_err_q, end_err_d;
  logic                 timeout_q, timeout_d;

  logic                 rise;
  logic                 last_bit;
  logic                 crc_cover;
  logic                 crc_clr, crc_en;
  logic [6:0]           crc_val;
  logic [135:0]         frame_shift;
  logic [TIMEOUT_W:0]   tcnt_inc;
  logic                 unused_frame_msb;

  assign rise        = SD_CLK & ~sd_clk_q;
  assign frame_shift = {frame_q[134:0], CMD_IN};
  assign tcnt_inc    = {1'b0, tcnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign last_bit    = (bcnt_q == (long_q ? LONG_LAST_CNT : SHORT_LAST_CNT));
  // bcnt_q counts bits already taken, so the incoming frame bit is LEN-1-bcnt_q.
  assign crc_cover   = long_q ? ((bcnt_q >= LONG_CRC_FIRST_CNT) && (bcnt_q <= LONG_CRC_LAST_CNT))
                              : (bcnt_q <= SHORT_CRC_LAST_CNT);
  assign unused_frame_msb = frame_q[135];

  sd_crc7_serial u_crc (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (crc_clr),
    .EN     (crc_en),
    .BIT_IN (CMD_IN),
    .CRC    (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    limit_d   = limit_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    frame_d   = frame_q;
    data_d    = data_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    timeout_d = timeout_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          long_d    = LONG;
          limit_d   = TIMEOUT_LIMIT;
          tcnt_d    = '0;
          bcnt_d    = 8'd0;
          frame_d   = '0;
          data_d    = '0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (rise) begin
          if (!CMD_IN) begin
            // A zero start bit leaves a cleared CRC unchanged, so clearing here covers it.
            crc_clr = 1'b1;
            frame_d = frame_shift;
            bcnt_d  = 8'd1;
            state_d = ST_RECV;
          end else begin
            tcnt_d = tcnt_inc[TIMEOUT_W-1:0];
            if (tcnt_inc >= {1'b0, limit_q}) begin
              timeout_d = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
      end

      ST_RECV: begin
        if (rise) begin
          frame_d = frame_shift;
          bcnt_d  = bcnt_q + 8'd1;
          crc_en  = crc_cover;
          if (last_bit) begin
            crc_err_d = (frame_q[6:0] != crc_val);
            end_err_d = ~CMD_IN;
            data_d    = long_q ? {frame_shift[127:1], 1'b0}
                               : {90'd0, frame_shift[45:8]};
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sd_clk_q  <= 1'b0;
      long_q    <= 1'b0;
      limit_q   <= '0;
      tcnt_q    <= '0;
      bcnt_q    <= 8'd0;
      frame_q   <= '0;
      data_q    <= '0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_clk_q  <= SD_CLK;
      long_q    <= long_d;
      limit_q   <= limit_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign RSP_VALID = (state_q == ST_DONE);
  assign RSP_DATA  = data_q;
  assign CRC_ERR   = crc_err_q;
  assign END_ERR   = end_err_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// Table-driven bench for sd_cmd_response_receiver: SD_CLK = CLK/4, frames sent MSB first.
module tb_sd_cmd_response_receiver;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SD_CLK;
  logic         CMD_IN;
  logic         START;
  logic         LONG;
  logic [7:0]   TIMEOUT_LIMIT;
  logic         BUSY;
  logic         RSP_VALID;
  logic [127:0] RSP_DATA;
  logic         CRC_ERR;
  logic         END_ERR;
  logic         TIMEOUT;

  sd_cmd_response_receiver #(.TIMEOUT_W(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SD_CLK        (SD_CLK),
    .CMD_IN        (CMD_IN),
    .START         (START),
    .LONG          (LONG),
    .TIMEOUT_LIMIT (TIMEOUT_LIMIT),
    .BUSY          (BUSY),
    .RSP_VALID     (RSP_VALID),
    .RSP_DATA      (RSP_DATA),
    .CRC_ERR       (CRC_ERR),
    .END_ERR       (END_ERR),
    .TIMEOUT       (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         isLong;
    logic [7:0]   limit;
    int           idle;
    int           nbits;
    logic [135:0] frame;
    logic [127:0] expData;
    logic         expCrc;
    logic         chkCrc;
    logic         expEnd;
    logic         expTo;
  } vec_t;

  vec_t         vecs[8];
  int           testsRun = 0;
  int           testsFailed = 0;
  int           validSeen;
  logic [127:0] capData;
  logic         capCrc, capEnd, capTo;

  // Reference CRC7 over frame bits hi..lo, taps of x^7+x^3+1 applied explicitly.
  function automatic logic [6:0] crcModel(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c[0] = ~c[0];
        c[3] = ~c[3];
      end
    end
    return c;
  endfunction

  function automatic vec_t mkVec(input logic isLong, input logic [7:0] limit, input int idle,
                                 input int nbits, input logic [135:0] frame,
                                 input logic [127:0] expData, input logic expCrc,
                                 input logic chkCrc, input logic expEnd, input logic expTo);
    vec_t v;
    v.isLong = isLong;  v.limit = limit;   v.idle = idle;     v.nbits = nbits;
    v.frame = frame;    v.expData = expData;
    v.expCrc = expCrc;  v.chkCrc = chkCrc; v.expEnd = expEnd; v.expTo = expTo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (RSP_VALID === 1'b1) begin
      validSeen++;
      capData = RSP_DATA;
      capCrc  = CRC_ERR;
      capEnd  = END_ERR;
      capTo   = TIMEOUT;
    end
  endtask

  // One SD_CLK period: two CLK cycles low with the bit set up, then two high.
  task automatic sdBit(input logic b, input bit isLast, input string tag);
    SD_CLK = 1'b0;
    CMD_IN = b;
    step();
    step();
    SD_CLK = 1'b1;
    step();
    if (isLast) checkOutput({tag, " valid latency"}, {127'd0, RSP_VALID}, 128'd1);
    step();
    if (isLast) checkOutput({tag, " busy drop"}, {127'd0, BUSY}, 128'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int total;
    validSeen = 0;
    capData = 'x; capCrc = 1'bx; capEnd = 1'bx; capTo = 1'bx;
    total = v.idle + v.nbits;
    SD_CLK = 1'b0;
    CMD_IN = 1'b1;
    START = 1'b1;
    LONG = v.isLong;
    TIMEOUT_LIMIT = v.limit;
    step();
    START = 1'b0;
    LONG = 1'b0;
    TIMEOUT_LIMIT = 8'd0;
    checkOutput({tag, " busy rise"}, {127'd0, BUSY}, 128'd1);
    for (int k = 0; k < v.idle; k++) sdBit(1'b1, (k == total - 1), tag);
    for (int i = v.nbits - 1; i >= 0; i--) sdBit(v.frame[i], (i == 0), tag);
    CMD_IN = 1'b1;
    step();
    step();
    checkOutput({tag, " valid pulses"}, 128'(validSeen), 128'd1);
    checkOutput({tag, " data"}, capData, v.expData);
    checkOutput({tag, " timeout"}, {127'd0, capTo}, {127'd0, v.expTo});
    checkOutput({tag, " end_err"}, {127'd0, capEnd}, {127'd0, v.expEnd});
    if (v.chkCrc) checkOutput({tag, " crc_err"}, {127'd0, capCrc}, {127'd0, v.expCrc});
  endtask

  logic [119:0] cid;
  logic [6:0]   cidCrc;
  logic [135:0] tmp;
  logic [135:0] goodShort;

  initial begin
    RST = 1'b1; START = 1'b0; LONG = 1'b0; TIMEOUT_LIMIT = 8'd0;
    SD_CLK = 1'b0; CMD_IN = 1'b1;
    validSeen = 0;

    goodShort = 136'h08_000001AA_13;
    cid = 120'h03_5344_5344_3136_4780_1234_5678_00A1;
    tmp = {2'b00, 6'h3F, cid, 7'h00, 1'b1};
    cidCrc = crcModel(tmp, 127, 8);

    vecs[0] = mkVec(1'b0, 8'd20, 5, 48, goodShort, 128'h08_0000_01AA, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[1] = mkVec(1'b0, 8'd20, 5, 48, 136'h08_000001AA_15, 128'h08_0000_01AA, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[2] = mkVec(1'b0, 8'd20, 5, 48, 136'h08_000001AA_12, 128'h08_0000_01AA, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[3] = mkVec(1'b1, 8'd20, 3, 136, {2'b00, 6'h3F, cid, cidCrc, 1'b1},
                    {cid, cidCrc, 1'b0}, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[4] = mkVec(1'b1, 8'd20, 3, 136, {2'b00, 6'h3F, cid, cidCrc ^ 7'h01, 1'b1},
                    {cid, cidCrc ^ 7'h01, 1'b0}, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[5] = mkVec(1'b0, 8'd8, 8, 0, 136'd0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[6] = mkVec(1'b0, 8'd0, 1, 0, 136'd0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tmp = {88'd0, 2'b00, 6'd17, 32'h0000_0900, 7'h00, 1'b1};
    tmp[7:1] = crcModel(tmp, 47, 8);
    vecs[7] = mkVec(1'b0, 8'd8, 7, 48, tmp, {90'd0, 6'd17, 32'h0000_0900}, 1'b0, 1'b1, 1'b0, 1'b0);

    step(); step(); step();
    RST = 1'b0;
    step();
    checkOutput("reset busy", {127'd0, BUSY}, 128'd0);
    checkOutput("reset valid", {127'd0, RSP_VALID}, 128'd0);
    checkOutput("reset data", RSP_DATA, 128'd0);
    checkOutput("reset crc_err", {127'd0, CRC_ERR}, 128'd0);
    checkOutput("reset end_err", {127'd0, END_ERR}, 128'd0);
    checkOutput("reset timeout", {127'd0, TIMEOUT}, 128'd0);

    for (int n = 0; n < 8; n++) applyStimulus(vecs[n], $sformatf("vec%0d", n));

    // Reset partway through a short frame, right after frame bit 20 is sampled.
    validSeen = 0;
    START = 1'b1; LONG = 1'b0; TIMEOUT_LIMIT = 8'd20;
    step();
    START = 1'b0;
    for (int k = 0; k < 5; k++) sdBit(1'b1, 1'b0, "rst");
    for (int i = 47; i >= 20; i--) sdBit(goodShort[i], 1'b0, "rst");
    checkOutput("rst no early valid", 128'(validSeen), 128'd0);
    checkOutput("rst busy before", {127'd0, BUSY}, 128'd1);
    SD_CLK = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("rst busy", {127'd0, BUSY}, 128'd0);
    checkOutput("rst valid", {127'd0, RSP_VALID}, 128'd0);
    checkOutput("rst data", RSP_DATA, 128'd0);
    checkOutput("rst flags", {125'd0, CRC_ERR, END_ERR, TIMEOUT}, 128'd0);
    for (int i = 19; i >= 0; i--) sdBit(goodShort[i], 1'b0, "rst");
    for (int k = 0; k < 30; k++) sdBit(1'b0, 1'b0, "rst");
    checkOutput("rst stays idle", {127'd0, BUSY}, 128'd0);
    checkOutput("rst no stray valid", 128'(validSeen), 128'd0);
    applyStimulus(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
